// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader that fills instruction memory and gates CPU reset
module imem_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  // Largest image that fits in the instruction memory, in words.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [15:0]       word_idx_q, word_idx_d;
  logic [7:0]        xor_q, xor_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              accept;
  logic [15:0]       new_len;

  assign rx_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA)   || (state_q == S_CSUM);
  assign accept     = rx_valid && rx_ready;
  assign new_len    = {len_q[7:0], rx_data};

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

  // Next-state, word assembly, checksum and registered status outputs.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_idx_d   = word_idx_q;
    xor_d        = xor_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          // Every (re)load starts from a clean checksum and word address 0.
          state_d    = S_LEN_HI;
          xor_d      = 8'h00;
          word_idx_d = 16'h0000;
          byte_cnt_d = 2'd0;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d   = {8'h00, rx_data};
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = new_len;
          if (new_len == 16'h0000) begin
            state_d = S_CSUM;
          end else if ({1'b0, new_len} > MAX_LEN) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          shift_d    = {shift_q[15:0], rx_data};
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_idx_q[ADDR_W-1:0];
            imem_wdata_d = {shift_q, rx_data};
            word_idx_d   = word_idx_q + 16'd1;
            if (word_idx_q == len_q - 16'd1) begin
              state_d = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Status follows the state being entered so it is valid from the same edge.
    cpu_reset_d = (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
    error_d     = (state_d == S_ERR);
  end

  // State and output registers; reset abandons any frame and drops a pending write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_q        <= 16'h0000;
      byte_cnt_q   <= 2'd0;
      shift_q      <= 24'h000000;
      word_idx_q   <= 16'h0000;
      xor_q        <= 8'h00;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h00000000;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      word_idx_q   <= word_idx_d;
      xor_q        <= xor_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader against a frame-level model
module tb_imem_loader;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LOG_N  = 8192;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  // Write log: every imem write in order, as the instruction memory would see it.
  int          we_count  = 0;
  int          we_consec = 0;
  logic        prev_we   = 1'b0;
  logic [15:0] log_addr [LOG_N];
  logic [31:0] log_data [LOG_N];

  always @(negedge clk) begin
    if (imem_we) begin
      if (we_count < LOG_N) begin
        log_addr[we_count] = 16'(imem_addr);
        log_data[we_count] = imem_wdata;
      end
      we_count++;
      if (prev_we) we_consec++;
    end
    prev_we = imem_we;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xsum(input logic [31:0] w[$]);
    logic [7:0] x = 8'h00;
    foreach (w[i]) x = x ^ w[i][31:24] ^ w[i][23:16] ^ w[i][15:8] ^ w[i][7:0];
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit mid_start);
    int n = 0;
    @(negedge clk);
    if (gaps) begin
      while ($urandom_range(0, 2) == 0) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        start    = mid_start && ($urandom_range(0, 1) == 1);
        @(negedge clk);
      end
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) stalls++;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[$], input logic [7:0] csum,
                            input bit gaps, input bit mid_start);
    logic [15:0] len;
    logic [31:0] word;
    len = 16'(w.size());
    send_byte(len[15:8], gaps, 1'b0);
    send_byte(len[7:0], gaps, 1'b0);
    foreach (w[i]) begin
      word = w[i];
      for (int b = 3; b >= 0; b--) send_byte(word[8*b +: 8], gaps, mid_start);
    end
    send_byte(csum, gaps, 1'b0);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (rx_ready !== 1'b0)   begin n_fail++; $display("FAIL reset_rx_ready got %b exp 0", rx_ready); end
    n_checks++; if (imem_we !== 1'b0)    begin n_fail++; $display("FAIL reset_imem_we got %b exp 0", imem_we); end
    n_checks++; if (imem_addr !== '0)    begin n_fail++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
    n_checks++; if (imem_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_imem_wdata got %h exp 0", imem_wdata); end
    n_checks++; if (cpu_reset !== 1'b1)  begin n_fail++; $display("FAIL reset_cpu_reset got %b exp 1", cpu_reset); end
    n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_checks++; if (error !== 1'b0)      begin n_fail++; $display("FAIL reset_error got %b exp 0", error); end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_ready !== 1'b0 || cpu_reset !== 1'b1) begin n_fail++; $display("FAIL idle_hold got rdy=%b cpu_reset=%b exp 0/1", rx_ready, cpu_reset); end
  endtask

  // Two-word image; the XOR of its eight payload bytes is 0x21.
  task automatic test_good_frame();
    logic [31:0] w[$];
    int base = we_count;
    w = '{32'h24080005, 32'h00000008};
    pulse_start();
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL t1_ready_len_hi got %b exp 1", rx_ready); end
    send_frame(w, xsum(w), 1'b0, 1'b0);
    n_checks++; if (we_count - base !== 2) begin n_fail++; $display("FAIL t1_write_count got %0d exp 2", we_count - base); end
    n_checks++; if (log_addr[base] !== 16'd0 || log_data[base] !== 32'h24080005) begin n_fail++; $display("FAIL t1_word0 got %0d:%h exp 0:24080005", log_addr[base], log_data[base]); end
    n_checks++; if (log_addr[base+1] !== 16'd1 || log_data[base+1] !== 32'h00000008) begin n_fail++; $display("FAIL t1_word1 got %0d:%h exp 1:00000008", log_addr[base+1], log_data[base+1]); end
    n_checks++; if ({done, cpu_reset, error, rx_ready} !== 4'b1000) begin n_fail++; $display("FAIL t1_status got done/cpu_reset/error/rdy=%b exp 1000", {done, cpu_reset, error, rx_ready}); end
    n_checks++; if (we_consec !== 0) begin n_fail++; $display("FAIL t1_we_width got %0d multi-cycle strobes exp 0", we_consec); end
  endtask

  task automatic test_bad_csum();
    logic [31:0] w[$];
    int base = we_count;
    w = '{32'h24080005, 32'h00000008};
    pulse_start();
    send_frame(w, 8'h28, 1'b0, 1'b0);
    n_checks++; if (we_count - base !== 2) begin n_fail++; $display("FAIL t2_write_count got %0d exp 2", we_count - base); end
    n_checks++; if (log_data[base] !== 32'h24080005 || log_data[base+1] !== 32'h00000008) begin n_fail++; $display("FAIL t2_words got %h %h exp 24080005 00000008", log_data[base], log_data[base+1]); end
    n_checks++; if ({done, cpu_reset, error} !== 3'b011) begin n_fail++; $display("FAIL t2_status got done/cpu_reset/error=%b exp 011", {done, cpu_reset, error}); end
  endtask

  task automatic test_len_overflow();
    int base = we_count;
    pulse_start();
    send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    n_checks++; if ({error, done, cpu_reset, rx_ready} !== 4'b1010) begin n_fail++; $display("FAIL t3_status got error/done/cpu_reset/rdy=%b exp 1010", {error, done, cpu_reset, rx_ready}); end
    repeat (8) @(negedge clk);
    n_checks++; if (we_count !== base) begin n_fail++; $display("FAIL t3_no_write got %0d writes exp 0", we_count - base); end
  endtask

  task automatic test_empty_then_reload();
    logic [31:0] w[$];
    int base = we_count;
    pulse_start();
    send_frame(w, 8'h00, 1'b0, 1'b0);
    n_checks++; if ({done, cpu_reset, error} !== 3'b100 || we_count !== base) begin n_fail++; $display("FAIL t4_empty got done/cpu_reset/error=%b writes=%0d exp 100 0", {done, cpu_reset, error}, we_count - base); end
    pulse_start();
    n_checks++; if ({done, cpu_reset} !== 2'b01) begin n_fail++; $display("FAIL t4_restart got done/cpu_reset=%b exp 01", {done, cpu_reset}); end
    w = '{32'hAABBCCDD};
    send_frame(w, 8'h00, 1'b0, 1'b0);
    n_checks++; if (we_count - base !== 1 || log_addr[base] !== 16'd0 || log_data[base] !== 32'hAABBCCDD) begin n_fail++; $display("FAIL t4_word got n=%0d %0d:%h exp 1 0:aabbccdd", we_count - base, log_addr[base], log_data[base]); end
    n_checks++; if ({done, cpu_reset, error} !== 3'b100) begin n_fail++; $display("FAIL t4_done got done/cpu_reset/error=%b exp 100", {done, cpu_reset, error}); end
  endtask

  task automatic test_gaps_and_mid_start();
    logic [31:0] w[$];
    int base;
    for (int i = 0; i < 3; i++) w.push_back($urandom);
    for (int pass = 0; pass < 2; pass++) begin
      base = we_count;
      pulse_start();
      send_frame(w, xsum(w), pass == 1, pass == 1);
      n_checks++; if (we_count - base !== 3) begin n_fail++; $display("FAIL t5_count pass %0d got %0d exp 3", pass, we_count - base); end
      for (int i = 0; i < 3; i++) begin
        n_checks++; if (log_addr[base+i] !== 16'(i) || log_data[base+i] !== w[i]) begin n_fail++; $display("FAIL t5_word%0d pass %0d got %0d:%h exp %0d:%h", i, pass, log_addr[base+i], log_data[base+i], i, w[i]); end
      end
      n_checks++; if ({done, cpu_reset, error} !== 3'b100) begin n_fail++; $display("FAIL t5_status pass %0d got %b exp 100", pass, {done, cpu_reset, error}); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w[$];
    logic [31:0] word;
    int base = we_count;
    w = '{32'h11223344, 32'h55667788};
    pulse_start();
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      word = w[i/4];
      send_byte(word[8*(3 - i%4) +: 8], 1'b0, 1'b0);
    end
    reset = 1'b0;
    #1;
    n_checks++; if ({rx_ready, imem_we, cpu_reset, done, error} !== 5'b00100 || imem_addr !== '0 || imem_wdata !== 32'h0) begin n_fail++; $display("FAIL t6_reset got rdy/we/cpu/done/err=%b addr=%h wdata=%h exp 00100 0 0", {rx_ready, imem_we, cpu_reset, done, error}, imem_addr, imem_wdata); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_checks++; if (we_count - base !== 1) begin n_fail++; $display("FAIL t6_partial got %0d writes exp 1", we_count - base); end
    base = we_count;
    w = '{32'hCAFEF00D, 32'h0BADBEEF};
    pulse_start();
    send_frame(w, xsum(w), 1'b0, 1'b0);
    n_checks++; if (we_count - base !== 2 || log_addr[base] !== 16'd0 || log_data[base] !== 32'hCAFEF00D || log_data[base+1] !== 32'h0BADBEEF) begin n_fail++; $display("FAIL t6_reload got n=%0d %h %h exp 2 cafef00d 0badbeef", we_count - base, log_data[base], log_data[base+1]); end
    n_checks++; if ({done, cpu_reset, error} !== 3'b100) begin n_fail++; $display("FAIL t6_status got %b exp 100", {done, cpu_reset, error}); end
  endtask

  task automatic test_random_frames();
    logic [31:0] w[$];
    logic [7:0]  csum;
    bit          bad;
    int          base;
    int          len;
    int          bad_words;
    for (int r = 0; r < 10; r++) begin
      w.delete();
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) w.push_back($urandom);
      bad  = ($urandom_range(0, 3) == 0);
      csum = xsum(w) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
      base = we_count;
      pulse_start();
      send_frame(w, csum, r[0], r[0]);
      bad_words = 0;
      for (int i = 0; i < len; i++) if (log_addr[base+i] !== 16'(i) || log_data[base+i] !== w[i]) bad_words++;
      n_checks++; if (we_count - base !== len || bad_words !== 0) begin n_fail++; $display("FAIL rand%0d_words got n=%0d wrong=%0d exp n=%0d wrong=0", r, we_count - base, bad_words, len); end
      n_checks++; if ({done, cpu_reset, error} !== (bad ? 3'b011 : 3'b100)) begin n_fail++; $display("FAIL rand%0d_status got %b exp %b", r, {done, cpu_reset, error}, bad ? 3'b011 : 3'b100); end
    end
  endtask

  task automatic test_max_len();
    logic [31:0] w[$];
    int base = we_count;
    int bad_words = 0;
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    pulse_start();
    send_frame(w, xsum(w), 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) if (log_addr[base+i] !== 16'(i) || log_data[base+i] !== w[i]) bad_words++;
    n_checks++; if (we_count - base !== DEPTH || bad_words !== 0) begin n_fail++; $display("FAIL max_len_words got n=%0d wrong=%0d exp n=%0d wrong=0", we_count - base, bad_words, DEPTH); end
    n_checks++; if ({done, cpu_reset, error} !== 3'b100) begin n_fail++; $display("FAIL max_len_status got %b exp 100", {done, cpu_reset, error}); end
  endtask

  task automatic test_back_to_back();
    n_checks++; if (we_consec !== 0) begin n_fail++; $display("FAIL back_to_back_we_width got %0d multi-cycle strobes exp 0", we_consec); end
    n_checks++; if (stalls !== 0) begin n_fail++; $display("FAIL handshake_timeout got %0d stalled bytes exp 0", stalls); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_len_overflow();
    test_empty_then_reload();
    test_gaps_and_mid_start();
    test_reset_mid_load();
    test_random_frames();
    test_max_len();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
